// File: rtl/pong_pkg.sv
// Shared state encodings, winner codes and widths for the Pong match sequencer.
package pong_pkg;

   localparam int SCORE_W = 4;
   localparam int CNT_W   = 25;

   typedef enum logic [2:0] {
      ST_IDLE   = 3'd0,
      ST_SERVE  = 3'd1,
      ST_PLAY   = 3'd2,
      ST_SCORED = 3'd3,
      ST_OVER   = 3'd4
   } match_state_e;

   localparam logic [1:0] WIN_NONE  = 2'b00;
   localparam logic [1:0] WIN_LEFT  = 2'b01;
   localparam logic [1:0] WIN_RIGHT = 2'b10;

endpackage

// File: rtl/pong_match_ctrl_if.sv
// Link between the match sequencer (master) and the ball/paddle datapath (slave).
interface pong_match_ctrl_if;

   logic goal_l;
   logic goal_r;
   logic paddle_hit;
   logic guiwei;
   logic ball_en;
   logic serve_dir;
   logic speed_sel;

   modport master (
      input  goal_l, goal_r, paddle_hit,
      output guiwei, ball_en, serve_dir, speed_sel
   );

   modport slave (
      output goal_l, goal_r, paddle_hit,
      input  guiwei, ball_en, serve_dir, speed_sel
   );

endinterface

// File: rtl/pong_match_ctrl_key_edge.sv
// key_edge: 2-FF synchronizer plus registered falling-edge pulse for an active-low key.
module key_edge (
   input  logic clk,
   input  logic rst,
   input  logic key_n,
   output logic press
);

   logic sync1_reg;
   logic sync2_reg;
   logic prev_reg;
   logic press_reg;

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         sync1_reg <= 1'b1;
         sync2_reg <= 1'b1;
         prev_reg  <= 1'b1;
         press_reg <= 1'b0;
      end else begin
         sync1_reg <= key_n;
         sync2_reg <= sync1_reg;
         prev_reg  <= sync2_reg;
         // Registered so the pulse comes from a flop, not from gating.
         press_reg <= prev_reg & ~sync2_reg;
      end
   end

   assign press = press_reg;

endmodule

// File: rtl/pong_match_ctrl.sv
// Pong round sequencer: serve countdown, rally speed-up, scoring and match end.
// Define PONG_DEUCE_EN to require a two-point lead to win.
module pong_match_ctrl
   import pong_pkg::*;
#(
   parameter int WIN_SCORE    = 7,
   parameter int SERVE_CYCLES = 25_000_000,
   parameter int HOLD_CYCLES  = 12_500_000,
   parameter int RALLY_FAST   = 8
) (
   input  logic                vga_clk,
   input  logic                sys_rst,
   input  logic                start_key,
   pong_match_ctrl_if.master   bus,
   output logic [SCORE_W-1:0]  score_l,
   output logic [SCORE_W-1:0]  score_r,
   output logic [1:0]          winner,
   output logic [2:0]          state
);

   localparam logic [2:0] S_IDLE   = ST_IDLE;
   localparam logic [2:0] S_SERVE  = ST_SERVE;
   localparam logic [2:0] S_PLAY   = ST_PLAY;
   localparam logic [2:0] S_SCORED = ST_SCORED;
   localparam logic [2:0] S_OVER   = ST_OVER;

   localparam logic [CNT_W-1:0]   SERVE_LOAD = CNT_W'(SERVE_CYCLES - 1);
   localparam logic [CNT_W-1:0]   HOLD_LOAD  = CNT_W'(HOLD_CYCLES - 1);
   localparam logic [CNT_W-1:0]   CNT_ONE    = CNT_W'(1);
   localparam logic [SCORE_W-1:0] SCORE_ONE  = SCORE_W'(1);
   localparam logic [SCORE_W-1:0] WIN_S      = SCORE_W'(WIN_SCORE);
   localparam logic [SCORE_W-1:0] WIN_M1     = SCORE_W'(WIN_SCORE - 1);
   localparam logic [3:0]         RALLY_TH   = 4'(RALLY_FAST);

   logic [2:0]         state_reg;
   logic [CNT_W-1:0]   cnt_reg;
   logic [3:0]         rally_reg;
   logic [SCORE_W-1:0] score_l_reg;
   logic [SCORE_W-1:0] score_r_reg;
   logic [1:0]         winner_reg;
   logic               serve_dir_reg;
   logic               press;
   logic [SCORE_W-1:0] score_l_next;
   logic [SCORE_W-1:0] score_r_next;

   key_edge u_start_key (
      .clk   (vga_clk),
      .rst   (sys_rst),
      .key_n (start_key),
      .press (press)
   );

   function automatic logic is_win(input logic [SCORE_W-1:0] a, input logic [SCORE_W-1:0] b);
`ifdef PONG_DEUCE_EN
      return (a >= WIN_S) && ({1'b0, a} >= ({1'b0, b} + 5'd2));
`else
      return (a == WIN_S) && (b != WIN_S);
`endif
   endfunction

   // goal_l has priority: a simultaneous goal_r is dropped.
   always_comb begin
      score_l_next = score_l_reg;
      score_r_next = score_r_reg;
      if (bus.goal_l) begin
         score_r_next = score_r_reg + SCORE_ONE;
      end else begin
         score_l_next = score_l_reg + SCORE_ONE;
      end
`ifdef PONG_DEUCE_EN
      if ((score_l_next == WIN_S) && (score_r_next == WIN_S)) begin
         score_l_next = WIN_M1;
         score_r_next = WIN_M1;
      end
`endif
   end

   always_ff @(posedge vga_clk or posedge sys_rst) begin
      if (sys_rst) begin
         state_reg     <= S_IDLE;
         cnt_reg       <= '0;
         rally_reg     <= '0;
         score_l_reg   <= '0;
         score_r_reg   <= '0;
         winner_reg    <= WIN_NONE;
         serve_dir_reg <= 1'b0;
      end else begin
         case (state_reg)
            S_IDLE, S_OVER: begin
               if (press) begin
                  state_reg     <= S_SERVE;
                  cnt_reg       <= SERVE_LOAD;
                  rally_reg     <= '0;
                  score_l_reg   <= '0;
                  score_r_reg   <= '0;
                  winner_reg    <= WIN_NONE;
                  serve_dir_reg <= 1'b0;
               end
            end
            S_SERVE: begin
               if (cnt_reg == '0) begin
                  state_reg <= S_PLAY;
               end else begin
                  cnt_reg <= cnt_reg - CNT_ONE;
               end
            end
            S_PLAY: begin
               if (bus.goal_l || bus.goal_r) begin
                  state_reg     <= S_SCORED;
                  cnt_reg       <= HOLD_LOAD;
                  rally_reg     <= '0;
                  score_l_reg   <= score_l_next;
                  score_r_reg   <= score_r_next;
                  serve_dir_reg <= ~bus.goal_l;
               end else if (bus.paddle_hit && (rally_reg != 4'hF)) begin
                  rally_reg <= rally_reg + 4'd1;
               end
            end
            S_SCORED: begin
               if (cnt_reg != '0) begin
                  cnt_reg <= cnt_reg - CNT_ONE;
               end else if (is_win(score_l_reg, score_r_reg)) begin
                  state_reg  <= S_OVER;
                  winner_reg <= WIN_LEFT;
               end else if (is_win(score_r_reg, score_l_reg)) begin
                  state_reg  <= S_OVER;
                  winner_reg <= WIN_RIGHT;
               end else begin
                  state_reg <= S_SERVE;
                  cnt_reg   <= SERVE_LOAD;
               end
            end
            default: state_reg <= S_IDLE;
         endcase
      end
   end

   assign bus.guiwei    = (state_reg != S_SERVE) && (state_reg != S_PLAY);
   assign bus.ball_en   = (state_reg == S_PLAY);
   assign bus.serve_dir = serve_dir_reg;
   assign bus.speed_sel = (state_reg == S_PLAY) && (rally_reg >= RALLY_TH);
   assign score_l       = score_l_reg;
   assign score_r       = score_r_reg;
   assign winner        = winner_reg;
   assign state         = state_reg;

endmodule

// File: doc/pong_match_ctrl.md
# pong_match_ctrl

Match sequencer for the Pong datapath. It owns the round state machine and drives the paddle modules' `guiwei` return-to-home and `s` speed-select inputs. It also enables the ball mover and keeps both players' scores. It sits between the key inputs, the ball module's goal and hit pulses, and the paddle and ball modules.

## Interface
- `WIN_SCORE`, 7: points needed to win (2..13).
- `SERVE_CYCLES`, 25_000_000: serve countdown length in `vga_clk` cycles (≥2, fits 25 bits).
- `HOLD_CYCLES`, 12_500_000: post-goal hold length in cycles (≥2, fits 25 bits).
- `RALLY_FAST`, 8: paddle hits in the current rally before `speed_sel` asserts (1..15).
- `vga_clk` in 1: sole clock.
- `sys_rst` in 1: asynchronous reset, active-high.
- `start_key` in 1: debounced start key, active-low, asynchronous to `vga_clk`.
- `goal_l` in 1: one-cycle pulse; ball passed the left paddle, so the right player scores.
- `goal_r` in 1: one-cycle pulse; ball passed the right paddle, so the left player scores.
- `paddle_hit` in 1: one-cycle pulse when either paddle returns the ball.
- `guiwei` out 1: paddle/ball home command, level.
- `ball_en` out 1: ball movement enable.
- `serve_dir` out 1: 0 = serve toward the left player, 1 = toward the right player.
- `speed_sel` out 1: drives the paddles' `s` input; 1 = fast.
- `score_l`, `score_r` out 4: scores, unsigned.
- `winner` out 2: 00 = none, 01 = left, 10 = right.
- `state` out 3: current state encoding, for the display and debug.

## Operation
- States and encodings: IDLE = 0, SERVE = 1, PLAY = 2, SCORED = 3, OVER = 4.
- Outputs are decoded from the state register. There are no combinational paths from inputs to outputs.
  - IDLE, SCORED and OVER: `guiwei` = 1, `ball_en` = 0.
  - SERVE: `guiwei` = 0, `ball_en` = 0.
  - PLAY: `guiwei` = 0, `ball_en` = 1.
- `start_key` passes through a 2-FF synchronizer, then a falling-edge detector, giving one `press` pulse per key press.
- IDLE → SERVE on `press`:
  - Clear both scores, `winner` and `rally`.
  - Set `serve_dir` = 0.
  - Load `cnt` = SERVE_CYCLES-1.
- SERVE: decrement `cnt` each cycle. When `cnt` = 0, go to PLAY.
- PLAY:
  - `paddle_hit` increments `rally`, saturating at 15.
  - `speed_sel` = 1 while in PLAY and `rally` ≥ RALLY_FAST; otherwise 0.
- PLAY → SCORED on `goal_l` or `goal_r`, on the same edge:
  - Increment the scoring player's score.
  - Set `serve_dir` toward the conceding player: `goal_l` gives 0, `goal_r` gives 1.
  - Clear `rally`.
  - Load `cnt` = HOLD_CYCLES-1.
- SCORED: decrement `cnt`. When `cnt` = 0:
  - If a win condition holds, go to OVER and set `winner`.
  - Otherwise, go to SERVE and load `cnt` = SERVE_CYCLES-1.
- OVER → SERVE on `press`, with the same clearing actions as IDLE → SERVE.
- Win condition without deuce: the score equals WIN_SCORE.
- Boundary rules:
  - `goal_l` and `goal_r` in the same cycle: `goal_l` wins and `goal_r` is dropped.
  - `paddle_hit` in the same cycle as a goal: ignored, because `rally` clears.
  - `press` in SERVE, PLAY or SCORED: ignored.
  - Goal and hit pulses outside PLAY: ignored.
  - `sys_rst` asserted in any state, including mid-countdown: immediate return to reset values.
- Reset values:
  - State: IDLE.
  - `guiwei` = 1, `ball_en` = 0, `serve_dir` = 0, `speed_sel` = 0.
  - `score_l` = `score_r` = 0, `winner` = 00.
  - `rally` = 0, `cnt` = 0, synchronizer flops = 1.

## Timing
- Key press: `start_key` low before edge N. `press` is high during cycle N+2. The state is SERVE from edge N+3.
- SERVE lasts exactly SERVE_CYCLES cycles. SCORED lasts exactly HOLD_CYCLES cycles.
- Goal latency: a goal pulse sampled at edge M gives an updated score and state SCORED after edge M, so `ball_en` = 0 in cycle M+1.
- `speed_sel` rises in the cycle after the RALLY_FAST-th hit is sampled.

## Configuration
- `PONG_DEUCE_EN` defined: win-by-two rule.
  - Win condition: the score is ≥ WIN_SCORE and leads the other score by ≥ 2.
  - If a score update produces a tie at WIN_SCORE, both scores load WIN_SCORE-1 on that same edge. Scores therefore never exceed WIN_SCORE+1 and never overflow.
- `PONG_DEUCE_EN` undefined: the first player to reach WIN_SCORE wins, and the tie rule is absent.

## Structure
- Package `pong_pkg` holds:
  - the state enum (3 bits),
  - the `winner` codes,
  - the score width (4) and counter width (25).
- Sub-module `key_edge` holds the 2-FF synchronizer and the falling-edge pulse generator. It is reusable for other keys.

## Test plan
All scenarios use WIN_SCORE=3, SERVE_CYCLES=4, HOLD_CYCLES=3 and RALLY_FAST=2.
- Reset, then release: `state` = 0, `guiwei` = 1, `ball_en` = 0, scores 0. A press drives `ball_en` = 1 exactly 4 cycles after SERVE entry.
- PLAY, 2× `paddle_hit`: `speed_sel` = 1 the cycle after the second hit. A following `goal_r` gives `score_l` = 1, `speed_sel` = 0, `serve_dir` = 1, then SCORED for 3 cycles, then SERVE.
- `goal_l` and `goal_r` in the same cycle: only `score_r` increments and `serve_dir` = 0.
- Three `goal_r` rounds, deuce off: `winner` = 01 and state OVER. A press restarts with scores 0.
- Deuce on, scores 2-2 then `goal_l` then `goal_r`: the 3-3 tie reloads 2-2, and `winner` stays 00. Two further `goal_l` give `winner` = 10 with `score_r` = 4.
- `sys_rst` pulsed mid-SERVE with `cnt` = 2: all outputs return to reset values asynchronously.
